// File: rtl/ula_arbiter_if.sv
// ---------------------------------------------------------------------------
// ula_arbiter_if : request/response bundle between the two ULA requesters
//                  and the ula_arbiter.
//
//   req_valid[1:0]  requester -> arbiter   request valid, bit i = port i
//   req_ready[1:0]  arbiter   -> requester request accepted (valid&ready)
//   req_op0/1       requester -> arbiter   00 add, 01 slt (unsigned), 10 AND, 11 illegal
//   req_a0/b0/a1/b1 requester -> arbiter   operands per port
//   rsp_valid[1:0]  arbiter   -> requester response valid, bit i = port i
//   rsp_ready[1:0]  requester -> arbiter   response consumed (valid&ready)
//   rsp_data        arbiter   -> requester shared result, qualified by rsp_valid
//   rsp_zero        arbiter   -> requester zero flag of rsp_data
//   rsp_err         arbiter   -> requester 1 = illegal opcode
//
//   master : the requester side (control unit + address/branch path)
//   slave  : the arbiter side
// ---------------------------------------------------------------------------
interface ula_arbiter_if #(
  parameter int W = 8
);
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_op0;
  logic [1:0]   req_op1;
  logic [W-1:0] req_a0;
  logic [W-1:0] req_b0;
  logic [W-1:0] req_a1;
  logic [W-1:0] req_b1;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_zero;
  logic         rsp_err;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );
endinterface

// File: rtl/ula_arbiter.sv
// ---------------------------------------------------------------------------
// ula_arbiter : two-port round-robin arbiter and sequencer for the shared
//               8-bit ULA (add / unsigned set-less-than / AND).
//
//   i_clock    single system clock, rising edge
//   i_reset    synchronous, active-high reset
//   bus        ula_arbiter_if.slave, request/response handshakes of both ports
//   o_ula_a    registered operand to ULA entrada1
//   o_ula_b    registered operand to ULA entrada2
//   o_ula_op   registered opcode to ULA ULAop (never 11)
//   i_ula_res  combinational result from ULA Resultado
//   i_ula_zero zero flag from ULA Zero
//
// Flow: IDLE arbitrates and latches operands -> EXEC lets the ULA settle and
// captures its result -> RESP holds the result until the owner consumes it.
// Peak throughput is one operation every three cycles.
// ---------------------------------------------------------------------------
module ula_arbiter #(
  parameter int W = 8
) (
  input  logic          i_clock,
  input  logic          i_reset,
  ula_arbiter_if.slave  bus,
  output logic [W-1:0]  o_ula_a,
  output logic [W-1:0]  o_ula_b,
  output logic [1:0]    o_ula_op,
  input  logic [W-1:0]  i_ula_res,
  input  logic          i_ula_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  state_t       r_state;
  state_t       w_next_state;

  logic         r_last_grant;   // port granted most recently; loses the next tie
  logic         r_cur_port;     // port owning the operation in flight
  logic         r_illegal;      // in-flight op was 11, bypass the ULA result
  logic [W-1:0] r_ula_a;
  logic [W-1:0] r_ula_b;
  logic [1:0]   r_ula_op;
  logic [W-1:0] r_rsp_data;
  logic         r_rsp_zero;
  logic         r_rsp_err;

  logic         w_winner;
  logic         w_accept;
  logic         w_rsp_done;
  logic [1:0]   w_sel_op;
  logic [W-1:0] w_sel_a;
  logic [W-1:0] w_sel_b;

  // Round-robin pick: a lone requester wins outright; on a tie the port that
  // was not granted last time wins. Value is don't-care when nobody requests.
  always_comb begin
    case (bus.req_valid)
      2'b01:   w_winner = 1'b0;
      2'b10:   w_winner = 1'b1;
      2'b11:   w_winner = ~r_last_grant;
      default: w_winner = 1'b0;
    endcase
  end

  assign w_sel_op = w_winner ? bus.req_op1 : bus.req_op0;
  assign w_sel_a  = w_winner ? bus.req_a1  : bus.req_a0;
  assign w_sel_b  = w_winner ? bus.req_b1  : bus.req_b0;

  // Reset gates the handshakes so nothing is accepted or delivered during the
  // reset cycle, even though the state register only clears on the edge.
  assign w_accept   = (r_state == IDLE) && (|bus.req_valid) && !i_reset;
  assign w_rsp_done = (r_state == RESP) && bus.rsp_ready[r_cur_port];

  // -------------------------------------------------------------------------
  // FSM process 1: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // -------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: the default assignment at the top of a combinational block covers
  // every path, so no latch is inferred when a branch leaves it untouched.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept)   w_next_state = EXEC;
      EXEC:                    w_next_state = RESP;
      RESP:    if (w_rsp_done) w_next_state = IDLE;
      default:                 w_next_state = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM process 3: handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    if (w_accept) begin
      bus.req_ready[w_winner] = 1'b1;
    end
    if ((r_state == RESP) && !i_reset) begin
      bus.rsp_valid[r_cur_port] = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers: operand latch on accept, result capture in EXEC.
  // They hold in every other cycle, which keeps the ULA inputs and the
  // response stable under backpressure.
  // -------------------------------------------------------------------------
  // NOTE: all datapath registers are reset (none is a memory array), so the
  // outputs are defined from the first cycle after reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_last_grant <= 1'b1;
      r_cur_port   <= 1'b0;
      r_illegal    <= 1'b0;
      r_ula_a      <= '0;
      r_ula_b      <= '0;
      r_ula_op     <= OP_ADD;
      r_rsp_data   <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cur_port   <= w_winner;
            r_last_grant <= w_winner;
            r_ula_a      <= w_sel_a;
            r_ula_b      <= w_sel_b;
            // An illegal opcode is remembered separately and the ULA is fed
            // a harmless add, so ULAop never carries 11.
            r_illegal    <= (w_sel_op == OP_ILLEGAL);
            r_ula_op     <= (w_sel_op == OP_ILLEGAL) ? OP_ADD : w_sel_op;
          end
        end
        EXEC: begin
          if (r_illegal) begin
            r_rsp_data <= '0;
            r_rsp_zero <= 1'b1;
            r_rsp_err  <= 1'b1;
          end else begin
            r_rsp_data <= i_ula_res;
            r_rsp_zero <= i_ula_zero;
            r_rsp_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ula_a      = r_ula_a;
  assign o_ula_b      = r_ula_b;
  assign o_ula_op     = r_ula_op;
  assign bus.rsp_data = r_rsp_data;
  assign bus.rsp_zero = r_rsp_zero;
  assign bus.rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_ula_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ula_arbiter : directed testbench for ula_arbiter. A behavioural ULA
// closes the loop on o_ula_* / i_ula_*; expected results are hand-computed.
// Inputs change on the falling edge and outputs are sampled 1 time unit
// later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_ula_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] ula_a;
  logic [7:0] ula_b;
  logic [1:0] ula_op;
  logic [7:0] ula_res;
  logic       ula_zero;

  int n_checks;
  int n_pass;

  ula_arbiter_if #(.W(8)) bus ();

  ula_arbiter #(.W(8)) dut (
    .i_clock    (clk),
    .i_reset    (reset),
    .bus        (bus.slave),
    .o_ula_a    (ula_a),
    .o_ula_b    (ula_b),
    .o_ula_op   (ula_op),
    .i_ula_res  (ula_res),
    .i_ula_zero (ula_zero)
  );

  // Behavioural stand-in for the shared ULA.
  always_comb begin
    case (ula_op)
      2'b00:   ula_res = ula_a + ula_b;
      2'b01:   ula_res = (ula_a < ula_b) ? 8'h01 : 8'h00;
      2'b10:   ula_res = ula_a & ula_b;
      default: ula_res = 8'h00;
    endcase
    ula_zero = (ula_res == 8'h00);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
    $fatal(1);
  end

  // One complete transaction on one port with rsp_ready already high.
  task automatic run_op(input bit port, input logic [1:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_d, input logic exp_z,
                        input logic exp_e, input string name);
    logic [1:0] oh;
    oh = port ? 2'b10 : 2'b01;
    @(negedge clk);
    if (port) begin bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b; end
    else      begin bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b; end
    bus.req_valid = oh;
    #1;
    n_checks++;
    if (bus.req_ready !== oh) $display("FAIL %s req_ready: got %b want %b", name, bus.req_ready, oh);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00)
      $display("FAIL %s exec handshake: got rsp_valid %b req_ready %b want 00 00", name, bus.rsp_valid, bus.req_ready);
    else n_pass++;
    n_checks++;
    if (ula_op === 2'b11 || ula_a !== a || ula_b !== b)
      $display("FAIL %s ula inputs: got a %h b %h op %b want a %h b %h op != 11", name, ula_a, ula_b, ula_op, a, b);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.rsp_valid !== oh) $display("FAIL %s rsp_valid: got %b want %b", name, bus.rsp_valid, oh);
    else n_pass++;
    n_checks++;
    if (bus.rsp_data !== exp_d || bus.rsp_zero !== exp_z || bus.rsp_err !== exp_e)
      $display("FAIL %s response: got data %h zero %b err %b want data %h zero %b err %b",
               name, bus.rsp_data, bus.rsp_zero, bus.rsp_err, exp_d, exp_z, exp_e);
    else n_pass++;
    @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 2'b11;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b00) $display("FAIL reset req_ready: got %b want 00", bus.req_ready);
    else n_pass++;
    n_checks++;
    if (bus.rsp_valid !== 2'b00 || bus.rsp_data !== 8'h00 || bus.rsp_zero !== 1'b0 || bus.rsp_err !== 1'b0)
      $display("FAIL reset response: got valid %b data %h zero %b err %b want 00 00 0 0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_err);
    else n_pass++;
    n_checks++;
    if (ula_a !== 8'h00 || ula_b !== 8'h00 || ula_op !== 2'b00)
      $display("FAIL reset ula regs: got a %h b %h op %b want 00 00 00", ula_a, ula_b, ula_op);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = 2'b00;
  endtask

  task automatic test_single_ops();
    run_op(1'b0, 2'b00, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b0, "p0_add_wrap");
    run_op(1'b1, 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, "p1_add_zero");
    run_op(1'b1, 2'b01, 8'h03, 8'h05, 8'h01, 1'b0, 1'b0, "p1_slt_true");
    run_op(1'b1, 2'b01, 8'h05, 8'h03, 8'h00, 1'b1, 1'b0, "p1_slt_false");
    run_op(1'b1, 2'b10, 8'hC3, 8'h3C, 8'h00, 1'b1, 1'b0, "p1_and_zero");
    run_op(1'b1, 2'b01, 8'h7F, 8'h80, 8'h01, 1'b0, 1'b0, "p1_slt_unsigned");
  endtask

  task automatic test_round_robin();
    logic [1:0] oh;
    logic [7:0] exp_d;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.req_op0 = 2'b00; bus.req_a0 = 8'h01; bus.req_b0 = 8'h02;  // -> 03
    bus.req_op1 = 2'b10; bus.req_a1 = 8'hF0; bus.req_b1 = 8'h3C;  // -> 30
    bus.req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      oh    = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (i % 2 == 0) ? 8'h03 : 8'h30;
      n_checks++;
      if (bus.req_ready !== oh) $display("FAIL rr grant %0d: got %b want %b", i, bus.req_ready, oh);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.req_ready !== 2'b00) $display("FAIL rr exec ready %0d: got %b want 00", i, bus.req_ready);
      else n_pass++;
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.rsp_valid !== oh || bus.rsp_data !== exp_d || bus.req_ready !== 2'b00)
        $display("FAIL rr response %0d: got valid %b data %h ready %b want %b %h 00",
                 i, bus.rsp_valid, bus.rsp_data, bus.req_ready, oh, exp_d);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.rsp_ready = 2'b10;  // port 0 stalls; port 1's ready must be ignored
    bus.req_op0 = 2'b00; bus.req_a0 = 8'h11; bus.req_b0 = 8'h22;  // -> 33
    bus.req_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    bus.req_op1 = 2'b10; bus.req_a1 = 8'hFF; bus.req_b1 = 8'h0F;  // -> 0F
    bus.req_valid = 2'b10;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b00) $display("FAIL bp exec ready: got %b want 00", bus.req_ready);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== 8'h33 || bus.req_ready !== 2'b00)
        $display("FAIL bp hold %0d: got valid %b data %h ready %b want 01 33 00",
                 k, bus.rsp_valid, bus.rsp_data, bus.req_ready);
      else n_pass++;
    end
    bus.rsp_ready = 2'b11;
    #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b01 || bus.req_ready !== 2'b00)
      $display("FAIL bp handshake cycle: got valid %b ready %b want 01 00", bus.rsp_valid, bus.req_ready);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b10)
      $display("FAIL bp next accept: got valid %b ready %b want 00 10", bus.rsp_valid, bus.req_ready);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== 8'h0F || bus.rsp_zero !== 1'b0)
      $display("FAIL bp p1 response: got valid %b data %h zero %b want 10 0f 0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_zero);
    else n_pass++;
    @(posedge clk);
  endtask

  task automatic test_illegal();
    run_op(1'b0, 2'b11, 8'h05, 8'h07, 8'h00, 1'b1, 1'b1, "p0_illegal");
    n_checks++;
    if (ula_op === 2'b11) $display("FAIL illegal ula_op held: got %b want != 11", ula_op);
    else n_pass++;
    // A legal op right after must clear the error flag.
    run_op(1'b0, 2'b10, 8'hAA, 8'h0F, 8'h0A, 1'b0, 1'b0, "p0_after_illegal");
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    bus.req_op0 = 2'b00; bus.req_a0 = 8'h01; bus.req_b0 = 8'h01;
    bus.req_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 2'b00;
    reset = 1'b1;
    #1;
    n_checks++;
    if (ula_a !== 8'h01 || bus.rsp_valid !== 2'b00)
      $display("FAIL midrst exec: got ula_a %h valid %b want 01 00", ula_a, bus.rsp_valid);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b00 || ula_a !== 8'h00 || bus.rsp_data !== 8'h00 || bus.rsp_err !== 1'b0)
      $display("FAIL midrst outputs: got valid %b ula_a %h data %h err %b want 00 00 00 0",
               bus.rsp_valid, ula_a, bus.rsp_data, bus.rsp_err);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.rsp_valid !== 2'b00) $display("FAIL midrst no response %0d: got %b want 00", k, bus.rsp_valid);
      else n_pass++;
    end
    run_op(1'b1, 2'b01, 8'h03, 8'h05, 8'h01, 1'b0, 1'b0, "post_reset_slt");
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    bus.req_op0 = 2'b00; bus.req_a0 = 8'h00; bus.req_b0 = 8'h00;
    bus.req_op1 = 2'b00; bus.req_a1 = 8'h00; bus.req_b1 = 8'h00;

    test_reset();
    test_single_ops();
    test_round_robin();
    test_backpressure();
    test_illegal();
    test_reset_mid_op();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ula_arbiter.md
# ula_arbiter

Two-port round-robin arbiter and sequencer for the shared 8-bit ULA (add, set-less-than, AND). Each requester presents an operation with a valid/ready handshake. The arbiter grants one requester, drives registered operands and opcode into the ULA, captures the combinational result and zero flag, and returns them to the granted requester with a valid/ready response. It sits between the control unit and any secondary ULA user, such as the address/branch path, so that a single ULA instance serves both.

## Interface
Parameters:
- W, 8, operand/result width (matches ULA; other values unsupported)

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid[1:0]  in  2  request valid, bit i = port i
- req_ready[1:0]  out  2  request accepted when valid&ready on same edge
- req_op0, req_op1  in  2 each  opcode: 00 add, 01 slt (unsigned), 10 AND, 11 illegal
- req_a0, req_b0, req_a1, req_b1  in  W each  operands
- rsp_valid[1:0]  out  2  response valid to port i
- rsp_ready[1:0]  in  2  response consumed when valid&ready
- rsp_data  out  W  result (shared, qualified by rsp_valid)
- rsp_zero  out  1  zero flag of result
- rsp_err  out  1  1 = illegal opcode 11
- ula_a, ula_b  out  W each  to ULA entrada1/entrada2, registered
- ula_op  out  2  to ULA ULAop, registered
- ula_res  in  W  from ULA Resultado
- ula_zero  in  1  from ULA Zero

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Arbitrate among the asserted req_valid bits.
  - If exactly one is valid, that port wins.
  - If both are valid, the port not in last_grant wins.
  - req_ready[winner]=1 combinationally; the other bit is 0.
  - On acceptance: latch the winner's a, b and op into ula_a/ula_b/ula_op, set cur_port=winner, update last_grant=winner, and go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC (one cycle):
  - The ULA settles on the registered inputs.
  - At the end of the cycle: rsp_data<=ula_res, rsp_zero<=ula_zero, rsp_err<=0, then go to RESP.
  - If the latched op is 11, the ULA is not consulted: rsp_data<=0, rsp_zero<=1, rsp_err<=1. During EXEC, ula_op is forced to 00 so that the ULA never sees 11.
- RESP:
  - rsp_valid[cur_port]=1, other bit 0.
  - rsp_data/zero/err are held stable until rsp_ready[cur_port]=1, then go to IDLE.
  - rsp_ready of the non-current port is ignored.
- req_ready is 0 in EXEC and RESP. Requests wait with valid held; requesters must not change operands while valid&!ready.
- The arbiter performs no arithmetic itself. Add wraps modulo 2^W (carry discarded, as the ULA does). slt is unsigned.
- ula_a/ula_b/ula_op hold their last values in IDLE and RESP.

## Timing
- Reset values: req_ready=0 during the reset cycle, rsp_valid=00, rsp_data=0, rsp_zero=0, rsp_err=0, ula_a=0, ula_b=0, ula_op=00, last_grant=1 (port 0 wins the first tie), state IDLE.
- Latency: accept at edge N; EXEC in cycle N+1; rsp_valid high in cycle N+2.
- If rsp_ready is already high in N+2, the next accept can occur at the earliest at edge N+3. Peak throughput is 1 op per 3 cycles.
- Backpressure: rsp_valid stays high for any number of cycles while rsp_ready[cur_port]=0, with data unchanged.
- Requests arriving in EXEC/RESP are not lost. They are arbitrated on the first IDLE cycle.
- Simultaneous events:
  - A new request in the same cycle as the response handshake is not accepted until the following IDLE cycle.
  - A port holding valid continuously while the other also requests alternates grants with it.
- Reset mid-operation (EXEC or RESP): on the next edge the block returns to IDLE. Any pending response is discarded without rsp_valid, and all outputs take their reset values.

## Test plan
- Port 0 requests add, a=8'hF0, b=8'h20, with rsp_ready[0]=1 -> req_ready[0] in cycle N, rsp_valid=01 in N+2, rsp_data=8'h10, rsp_zero=0, rsp_err=0.
- Port 1 requests add, 8'hFF+8'h01 -> rsp_data=8'h00, rsp_zero=1, rsp_valid=10. Port 1 requests slt, 8'h03,8'h05 -> 8'h01. Port 1 requests slt, 8'h05,8'h03 -> 8'h00, zero=1. Port 1 requests AND, 8'hC3&8'h3C -> 8'h00, zero=1.
- Both ports hold valid for 4 transactions after reset -> grant order 0,1,0,1. Each response goes only to its own rsp_valid bit with the correct data.
- Port 0 request with rsp_ready[0]=0 for 5 cycles -> rsp_valid[0] and rsp_data held constant for 5 cycles. req_ready=00 throughout, even with req_valid[1]=1. Port 1 is accepted in the cycle after the handshake.
- Port 0 op=11 -> ula_op never 11, rsp_err=1, rsp_data=0, rsp_zero=1.
- Assert reset during EXEC -> next cycle IDLE, rsp_valid=00 and no response ever delivered for that request. A fresh request afterwards completes normally.
